// File: rtl/ssram_responder_if.sv
// Bus-side signals of the pipelined SSRAM port. The shared fs_dq data bus is
// kept out of the interface and stays a plain inout on the responder.
interface ssram_responder_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32
) ();

  logic                  ssram_cs_n;
  logic                  ssram_adsc_n;
  logic                  ssram_we_n;
  logic                  ssram_oe_n;
  logic [DATA_W/8-1:0]   ssram_be_n;
  logic [ADDR_W-1:0]     fs_addr;

  // Memory controller side
  modport master (
    output ssram_cs_n,
    output ssram_adsc_n,
    output ssram_we_n,
    output ssram_oe_n,
    output ssram_be_n,
    output fs_addr
  );

  // SSRAM device side
  modport slave (
    input ssram_cs_n,
    input ssram_adsc_n,
    input ssram_we_n,
    input ssram_oe_n,
    input ssram_be_n,
    input fs_addr
  );

endinterface

// File: rtl/ssram_responder.sv
// Pipelined SSRAM device model: byte-lane writes into an internal array, reads
// returned on the shared dq bus READ_LATENCY edges after address capture.
// Also flags bus-protocol violations and counts accepted transactions.
module ssram_responder #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DATA_W       = 32,   // multiple of 8
  parameter int unsigned MEM_DEPTH    = 4096,
  parameter int unsigned READ_LATENCY = 2     // 1 or 2
) (
  input  logic                clk_clk,
  input  logic                rst_reset,
  ssram_responder_if.slave    bus,
  inout  wire  [DATA_W-1:0]   fs_dq,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count,
  output logic                proto_err
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0]       mem [MEM_DEPTH];

  logic                    cmd, wr_cmd, rd_cmd;
  logic                    unknown_cmd, out_of_range, contention;
  logic                    wr_en, rd_en;
  logic [IdxW-1:0]         idx;

  // vld_q[0] is loaded on the capture edge; vld_q[READ_LATENCY] is the output stage
  logic [READ_LATENCY:0]   vld_q, vld_d;
  logic [DATA_W-1:0]       dat_q [READ_LATENCY+1];
  logic [15:0]             rd_count_q, rd_count_d;
  logic [15:0]             wr_count_q, wr_count_d;
  logic                    proto_err_q, proto_err_d;
  logic                    out_valid, dq_drive;

  // Command decode and violation detection for the current edge
  always_comb begin
    cmd          = !bus.ssram_cs_n && !bus.ssram_adsc_n;
    wr_cmd       = cmd && !bus.ssram_we_n;
    rd_cmd       = cmd && bus.ssram_we_n;
    idx          = IdxW'(32'(bus.fs_addr) % MEM_DEPTH);
    // Only meaningful in 4-state simulation; constant false in hardware
    unknown_cmd  = cmd && $isunknown({bus.fs_addr, bus.ssram_we_n, bus.ssram_be_n});
    out_of_range = cmd && (32'(bus.fs_addr) >= MEM_DEPTH);
    wr_en        = wr_cmd && !unknown_cmd;
    rd_en        = rd_cmd && !unknown_cmd;
    contention   = wr_en && out_valid && !bus.ssram_oe_n;
  end

  // Next state of read pipeline valids, counters and sticky error flag
  always_comb begin
    vld_d       = {vld_q[READ_LATENCY-1:0], 1'b0};
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    proto_err_d = proto_err_q;
    if (rd_en) begin
      vld_d[0]   = 1'b1;
      rd_count_d = rd_count_q + 16'd1;
    end
    if (wr_en) begin
      wr_count_d = wr_count_q + 16'd1;
    end
    if (contention || out_of_range || unknown_cmd) begin
      proto_err_d = 1'b1;
    end
  end

  // Control state register; async reset drops all in-flight reads
  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      vld_q       <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Memory array and read data pipeline; neither is cleared by reset
  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (!bus.ssram_be_n[i]) begin
          mem[idx][8*i +: 8] <= fs_dq[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      dat_q[0] <= mem[idx];
    end
    for (int unsigned k = 1; k <= READ_LATENCY; k++) begin
      dat_q[k] <= dat_q[k-1];
    end
  end

  // dq is released as soon as oe_n rises or reset asserts (no output register)
  assign out_valid = vld_q[READ_LATENCY];
  assign dq_drive  = out_valid && !bus.ssram_oe_n;
  assign fs_dq     = dq_drive ? dat_q[READ_LATENCY] : {DATA_W{1'bz}};

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ssram_responder.sv
// Directed bench for ssram_responder with a transaction-level reference model.
module tb_ssram_responder;

  localparam int unsigned Lat   = 2;
  localparam int unsigned Depth = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  wire  [31:0] fs_dq;
  logic [15:0] rd_count, wr_count;
  logic        proto_err;

  logic        tb_wr_drive = 1'b0;
  logic [31:0] tb_wdata    = '0;

  int n_pass  = 0;
  int n_total = 0;

  ssram_responder_if #(.ADDR_W(20), .DATA_W(32)) bus ();

  ssram_responder #(
    .ADDR_W(20), .DATA_W(32), .MEM_DEPTH(Depth), .READ_LATENCY(Lat)
  ) dut (
    .clk_clk   (clk),
    .rst_reset (rst),
    .bus       (bus),
    .fs_dq     (fs_dq),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  // Reference model: word memory, read results scheduled by edge number
  logic [31:0] mmem  [int];
  logic [31:0] sched [int];
  int          edge_no = 0;
  logic [15:0] m_rd    = '0;
  logic [15:0] m_wr    = '0;
  logic        m_err   = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;

  // Bench drives write data, or 0 whenever the DUT must not be driving, so any
  // stray DUT drive shows up as a non-zero (or X) value on the bus.
  wire tb_en = tb_wr_drive || !(m_valid && !bus.ssram_oe_n);
  assign fs_dq = tb_en ? (tb_wr_drive ? tb_wdata : 32'h0) : 32'hzzzz_zzzz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      m_rd  = '0;
      m_wr  = '0;
      m_err = 1'b0;
    end else begin
      if (!bus.ssram_cs_n && !bus.ssram_adsc_n) begin
        int a;
        a = int'(bus.fs_addr) % Depth;
        if (int'(bus.fs_addr) >= Depth) m_err = 1'b1;
        if (!bus.ssram_we_n) begin
          m_wr = m_wr + 16'd1;
          if (m_valid && !bus.ssram_oe_n) begin
            m_err = 1'b1;
            if (bus.ssram_be_n != 4'hF) mmem.delete(a);
          end else begin
            logic [31:0] w;
            w = mmem.exists(a) ? mmem[a] : 32'h0;
            for (int i = 0; i < 4; i++) begin
              if (!bus.ssram_be_n[i]) w[8*i +: 8] = tb_wdata[8*i +: 8];
            end
            mmem[a] = w;
          end
        end else begin
          m_rd = m_rd + 16'd1;
          sched[edge_no + 1 + Lat] = mmem.exists(a) ? mmem[a] : 32'h0;
        end
      end
      edge_no++;
    end
    m_valid = sched.exists(edge_no);
    m_data  = m_valid ? sched[edge_no] : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("rd_count", 32'(rd_count), 32'(m_rd));
    chk("wr_count", 32'(wr_count), 32'(m_wr));
    chk("proto_err", 32'(proto_err), 32'(m_err));
    if (m_valid && !bus.ssram_oe_n) begin
      if (!tb_wr_drive) chk("dq_read", fs_dq, m_data);
    end else if (tb_wr_drive) begin
      chk("dq_wdata", fs_dq, tb_wdata);
    end else begin
      chk("dq_released", fs_dq, 32'h0);
    end
  end

  task automatic drive(input logic c, input logic w, input logic [19:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    @(posedge clk); #1;
    bus.ssram_cs_n   = ~c;
    bus.ssram_adsc_n = ~c;
    bus.ssram_we_n   = ~w;
    bus.fs_addr      = a;
    bus.ssram_be_n   = b;
    tb_wdata         = d;
    tb_wr_drive      = c & w;
  endtask

  task automatic wr(input logic [19:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b1, 1'b1, a, b, d);
  endtask

  task automatic rd(input logic [19:0] a);
    drive(1'b1, 1'b0, a, 4'hF, 32'h0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 20'h0, 4'hF, 32'h0);
  endtask

  // Read with literal checks: released before, exact data at Lat, released after
  task automatic rd_check(input string name, input logic [19:0] a, input logic [31:0] exp);
    rd(a);
    idle();
    idle();
    @(negedge clk) chk({name, "_early"}, fs_dq, 32'h0);
    idle();
    @(negedge clk) chk(name, fs_dq, exp);
    idle();
    @(negedge clk) chk({name, "_late"}, fs_dq, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
  endtask

  initial begin
    bus.ssram_cs_n   = 1'b1;
    bus.ssram_adsc_n = 1'b1;
    bus.ssram_we_n   = 1'b1;
    bus.ssram_oe_n   = 1'b0;
    bus.ssram_be_n   = 4'hF;
    bus.fs_addr      = '0;
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rd_count", 32'(rd_count), 32'h0);
    chk("reset_proto_err", 32'(proto_err), 32'h0);

    // 1: full-word write then read
    wr(20'h00010, 32'hDEADBEEF, 4'h0);
    rd_check("t1_read", 20'h00010, 32'hDEADBEEF);

    // 2: byte-lane merge
    do_reset();
    wr(20'h00000, 32'h11223344, 4'h0);
    wr(20'h00000, 32'hAABBCCDD, 4'b1010);
    rd_check("t2_merge", 20'h00000, 32'h11BB33DD);
    chk("t2_wr_count", 32'(wr_count), 32'd2);
    chk("t2_rd_count", 32'(rd_count), 32'd1);

    // 3: back-to-back streaming reads
    for (int i = 1; i <= 4; i++) wr(20'(i), 32'hA0 + 32'(i), 4'h0);
    for (int i = 1; i <= 4; i++) rd(20'(i));
    @(negedge clk) chk("t3_stream1", fs_dq, 32'hA1);
    for (int i = 2; i <= 4; i++) begin
      idle();
      @(negedge clk) chk("t3_stream", fs_dq, 32'hA0 + 32'(i));
    end
    idle();
    @(negedge clk) chk("t3_after", fs_dq, 32'h0);

    // 4: write while read data is driven -> contention, sticky
    do_reset();
    rd(20'h00010);
    idle();
    idle();
    wr(20'h00020, 32'h55555555, 4'hF);
    idle();
    @(negedge clk) chk("t4_err_set", 32'(proto_err), 32'h1);
    repeat (3) idle();
    @(negedge clk) chk("t4_err_sticky", 32'(proto_err), 32'h1);
    do_reset();
    rd(20'h00010);
    idle();
    idle();
    bus.ssram_oe_n = 1'b1;
    wr(20'h00020, 32'h55555555, 4'hF);
    idle();
    bus.ssram_oe_n = 1'b0;
    @(negedge clk) chk("t4_no_err", 32'(proto_err), 32'h0);

    // 5: reset with reads in flight
    rd(20'h00010);
    rd(20'h00001);
    rd(20'h00002);
    idle();
    #3 rst = 1'b1;
    #1;
    chk("t5_dq_released", fs_dq, 32'h0);
    chk("t5_rd_count", 32'(rd_count), 32'h0);
    chk("t5_wr_count", 32'(wr_count), 32'h0);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (4) idle();
    rd_check("t5_mem_kept", 20'h00010, 32'hDEADBEEF);

    // 6: counter wrap with null writes, then address aliasing
    do_reset();
    repeat (65536) wr(20'h00001, 32'hFFFFFFFF, 4'hF);
    idle();
    @(negedge clk);
    chk("t6_wr_wrap", 32'(wr_count), 32'h0);
    chk("t6_no_err", 32'(proto_err), 32'h0);
    rd_check("t6_null_kept", 20'h00001, 32'hA1);
    wr(20'h01000, 32'hCAFEF00D, 4'h0);
    rd_check("t6_alias", 20'h00000, 32'hCAFEF00D);
    chk("t6_oob_err", 32'(proto_err), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
